// File: rtl/eth_rx_word_packer.sv
// rtl/eth_rx_word_packer.sv - Ethernet RX byte stream to 32-bit FIFO word packer
//
// Packs received bytes little-endian into 32-bit words and writes them into the
// receive FIFO, followed by one status word per frame. The byte stream cannot
// be stalled, so a full FIFO truncates the frame and flags it.
//
// Ports:
//   ACLK, ARESET                      clock, synchronous active-high reset
//   rx_valid, rx_data, rx_last, rx_err byte stream from the MAC
//   fifo_full                         low guarantees one free entry next cycle
//   fifo_wr_en, fifo_wr_data          registered write strobe and data
//   frame_cnt                         status words written (wraps)
//   drop_cnt                          frames skipped entirely (wraps)
//   busy                              high whenever the FSM is not idle
module eth_rx_word_packer #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int LEN_WIDTH       = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  input  logic        rx_err,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PACK,
    S_DROP,
    S_STATUS,
    S_SKIP
  } state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_CNT = LEN_WIDTH'(MAX_FRAME_BYTES);
  localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);

  state_t               state_q, state_d;
  logic [1:0]           lane_q, lane_d;
  logic [31:0]          word_q, word_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic                 long_q, long_d;
  logic                 skip_q, skip_d;
  logic                 wr_en_d;
  logic [31:0]          wr_data_d;
  logic [15:0]          frame_cnt_d, drop_cnt_d;

  logic [LEN_WIDTH-1:0] cnt_inc;
  logic [31:0]          word_ins;
  logic                 word_done;
  logic                 at_max;
  logic [31:0]          status_word;

  assign busy = (state_q != S_IDLE);

  always_comb begin
    // Byte count saturates so the length field never wraps on giant frames.
    cnt_inc     = (cnt_q == {LEN_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
    at_max      = (cnt_inc == MAX_CNT);
    // Lanes above lane_q are always zero, so OR-ing in the byte is enough.
    word_ins    = word_q | (32'(rx_data) << {lane_q, 3'b000});
    // A word is also flushed at the byte limit so exactly MAX bytes reach the FIFO.
    word_done   = rx_last || (lane_q == 2'd3) || at_max;
    status_word = {err_q, ovf_q, long_q, 29'd0} | 32'(cnt_q);

    state_d     = state_q;
    lane_d      = lane_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    long_d      = long_q;
    skip_d      = skip_q;
    wr_en_d     = 1'b0;
    wr_data_d   = fifo_wr_data;
    frame_cnt_d = frame_cnt;
    drop_cnt_d  = drop_cnt;

    case (state_q)
      S_IDLE, S_PACK: begin
        if (rx_valid) begin
          cnt_d = cnt_inc;
          if (word_done) begin
            lane_d = 2'd0;
            word_d = 32'd0;
            if (fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = word_ins;
            end
          end else begin
            lane_d = lane_q + 2'd1;
            word_d = word_ins;
          end

          if (rx_last) begin
            err_d   = rx_err;
            state_d = S_STATUS;
          end else if (at_max) begin
            long_d  = 1'b1;
            state_d = S_DROP;
          end else if (word_done && fifo_full) begin
            state_d = S_DROP;
          end else begin
            state_d = S_PACK;
          end
        end
      end

      S_DROP: begin
        if (rx_valid) begin
          cnt_d = cnt_inc;
          if (rx_last) begin
            err_d   = rx_err;
            state_d = S_STATUS;
          end
        end
      end

      S_STATUS: begin
        // A frame starting while status is still pending is skipped whole.
        if (rx_valid) begin
          if (rx_last) begin
            drop_cnt_d = drop_cnt + 16'd1;
            skip_d     = 1'b0;
          end else begin
            skip_d = 1'b1;
          end
        end
        if (!fifo_full) begin
          wr_en_d     = 1'b1;
          wr_data_d   = status_word;
          frame_cnt_d = frame_cnt + 16'd1;
          cnt_d       = '0;
          err_d       = 1'b0;
          ovf_d       = 1'b0;
          long_d      = 1'b0;
          state_d     = skip_d ? S_SKIP : S_IDLE;
        end
      end

      S_SKIP: begin
        if (rx_valid && rx_last) begin
          drop_cnt_d = drop_cnt + 16'd1;
          skip_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      word_q       <= 32'd0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      long_q       <= 1'b0;
      skip_q       <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 32'd0;
      frame_cnt    <= 16'd0;
      drop_cnt     <= 16'd0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      long_q       <= long_d;
      skip_q       <= skip_d;
      fifo_wr_en   <= wr_en_d;
      fifo_wr_data <= wr_data_d;
      frame_cnt    <= frame_cnt_d;
      drop_cnt     <= drop_cnt_d;
    end
  end

endmodule
